// File: rtl/sigmoid_tansig_pkg.sv
// Shared constants, types and the fixed-to-float helper for the sigmoid/tansig pipeline.
package sigmoid_tansig_pkg;

    localparam int FLT_W         = 32;
    localparam int EXP_W         = 8;
    localparam int MAN_W         = 23;
    localparam int EXP_BIAS      = 127;
    localparam int FX_INT_W      = 3;
    localparam int FX_FRAC_W     = 16;
    localparam int FX_W          = FX_INT_W + FX_FRAC_W;
    localparam int LUT_STEP_LOG2 = 5;
    localparam int LUT_FRAC_W    = FX_FRAC_W - LUT_STEP_LOG2;
    localparam int LUT_ENTRIES   = (1 << (FX_INT_W + LUT_STEP_LOG2)) + 1;
    localparam int LUT_IDX_W     = FX_INT_W + LUT_STEP_LOG2 + 1;
    localparam int TQ_W          = 17;
    localparam int RES_W         = TQ_W + 1;
    localparam int RES_FRAC_W    = 17;

    // Biased exponents: 8.0 is the saturation threshold, 2^-12 the tanh(x)=x cutoff.
    localparam logic [EXP_W-1:0] SAT_EXP       = 8'(EXP_BIAS + 3);
    localparam logic [EXP_W-1:0] BYPASS_EXP    = 8'(EXP_BIAS - 12);
    localparam logic [EXP_W-1:0] FX_SHIFT_BASE = 8'(EXP_BIAS + MAN_W - FX_FRAC_W);
    localparam logic [TQ_W-1:0]  TQ_ONE        = 17'h1_0000;
    localparam logic [FLT_W-1:0] CANON_NAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_SAT,
        CLS_NAN,
        CLS_BYPASS
    } op_class_e;

    typedef struct packed {
        logic             valid;
        logic             mode;
        logic [FLT_W-1:0] data;
    } s0_t;

    typedef struct packed {
        logic             valid;
        logic             mode;
        op_class_e        cls;
        logic [FX_W-1:0]  fixed;
        logic [FLT_W-1:0] data;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             mode;
        op_class_e        cls;
        logic [TQ_W-1:0]  tanh_mag;
        logic [FLT_W-1:0] data;
    } s2_t;

    // r is unsigned with RES_FRAC_W fraction bits; truncation is exact since r fits the mantissa.
    function automatic logic [FLT_W-1:0] fix_to_float(input logic sign, input logic [RES_W-1:0] r);
        int               lead;
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] expo;
        logic [FLT_W-1:0] result;
        lead = 0;
        for (int i = 0; i < RES_W; i++) begin
            if (r[i]) lead = i;
        end
        man  = MAN_W'({{(MAN_W - RES_W){1'b0}}, r} << (MAN_W - lead));
        expo = EXP_W'(EXP_BIAS - RES_FRAC_W + lead);
        if (r == '0) result = '0;
        else         result = {sign, expo, man};
        return result;
    endfunction

endpackage

// File: rtl/sigmoid_tansig_tanh_lut.sv
// Combinational tanh table: q = round(tanh(k/32) * 2^16) for k = 0..256, built at elaboration.
module tanh_lut
    import sigmoid_tansig_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] k,
    output logic [TQ_W-1:0]      q
);

    function automatic real exp_pos(input real y);
        real z, term, sum;
        z    = y / 64.0;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 16; i++) begin
            term = term * z / real'(i);
            sum  = sum + term;
        end
        for (int i = 0; i < 6; i++) sum = sum * sum;
        return sum;
    endfunction

    function automatic logic [TQ_W-1:0] tanh_q16(input int idx);
        real x, e;
        x = real'(idx) / real'(1 << LUT_STEP_LOG2);
        e = exp_pos(2.0 * x);
        return TQ_W'($rtoi((e - 1.0) / (e + 1.0) * real'(1 << FX_FRAC_W) + 0.5));
    endfunction

    logic [TQ_W-1:0] table_w [LUT_ENTRIES];

    for (genvar g = 0; g < LUT_ENTRIES; g++) begin : g_tbl
        localparam logic [TQ_W-1:0] ENTRY = tanh_q16(g);
        assign table_w[g] = ENTRY;
    end

    assign q = (k >= 9'(LUT_ENTRIES)) ? table_w[LUT_ENTRIES-1] : table_w[k];

endmodule

// File: rtl/sigmoid_tansig.sv
// Pipelined tanh / sigmoid on IEEE-754 singles: operand register, decode, table interpolation, normalise.
module sigmoid_tansig
    import sigmoid_tansig_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [FLT_W-1:0] in_data,
    output logic             out_valid,
    output logic [FLT_W-1:0] out_data
);

    s0_t              s0_d, s0_q;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic             out_valid_d, out_valid_q;
    logic [FLT_W-1:0] out_data_d, out_data_q;

    logic [EXP_W-1:0]            dec_exp, dec_exp_eff, dec_shift;
    logic [MAN_W-1:0]            dec_man;
    logic [MAN_W:0]              dec_mant24;
    logic [LUT_IDX_W-1:0]        lut_k_lo, lut_k_hi;
    logic [TQ_W-1:0]             lut_q_lo, lut_q_hi, lut_diff;
    logic [TQ_W+LUT_FRAC_W-1:0]  lut_prod;
    logic [RES_W-1:0]            fin_res;

    always_comb begin
        s0_d       = '0;
        s0_d.valid = in_valid;
        s0_d.mode  = in_mode;
        s0_d.data  = in_data;
    end

    // Sigmoid halves the argument by stepping the exponent down before conversion.
    always_comb begin
        dec_exp     = s0_q.data[FLT_W-2:MAN_W];
        dec_man     = s0_q.data[MAN_W-1:0];
        dec_mant24  = {1'b1, dec_man};
        dec_exp_eff = dec_exp - {7'b0, s0_q.mode};
        dec_shift   = FX_SHIFT_BASE - dec_exp_eff;
        s1_d        = '0;
        s1_d.valid  = s0_q.valid;
        s1_d.mode   = s0_q.mode;
        s1_d.data   = s0_q.data;
        s1_d.cls    = CLS_NORMAL;
        if (dec_exp == '1)                                s1_d.cls = (dec_man != '0) ? CLS_NAN : CLS_SAT;
        else if (dec_exp == '0)                           s1_d.cls = CLS_ZERO;
        else if (!s0_q.mode && (dec_exp < BYPASS_EXP))    s1_d.cls = CLS_BYPASS;
        else if (dec_exp_eff >= SAT_EXP)                  s1_d.cls = CLS_SAT;
        else if (dec_shift < 8'(MAN_W + 1))               s1_d.fixed = FX_W'(dec_mant24 >> dec_shift);
    end

    assign lut_k_lo = {1'b0, s1_q.fixed[FX_W-1:LUT_FRAC_W]};
    assign lut_k_hi = lut_k_lo + LUT_IDX_W'(1);

    tanh_lut u_lut_lo (.k(lut_k_lo), .q(lut_q_lo));
    tanh_lut u_lut_hi (.k(lut_k_hi), .q(lut_q_hi));

    always_comb begin
        lut_diff   = lut_q_hi - lut_q_lo;
        lut_prod   = (TQ_W+LUT_FRAC_W)'(lut_diff) * (TQ_W+LUT_FRAC_W)'(s1_q.fixed[LUT_FRAC_W-1:0]);
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.mode  = s1_q.mode;
        s2_d.cls   = s1_q.cls;
        s2_d.data  = s1_q.data;
        case (s1_q.cls)
            CLS_SAT:    s2_d.tanh_mag = TQ_ONE;
            CLS_NORMAL: s2_d.tanh_mag = lut_q_lo + TQ_W'(lut_prod >> LUT_FRAC_W);
            default:    s2_d.tanh_mag = '0;
        endcase
    end

    // Result carried with 17 fraction bits so that 0.5 +/- 0.5*tanh stays exact.
    always_comb begin
        if (!s2_q.mode)          fin_res = {s2_q.tanh_mag, 1'b0};
        else if (s2_q.data[31])  fin_res = {1'b0, TQ_ONE} - {1'b0, s2_q.tanh_mag};
        else                     fin_res = {1'b0, TQ_ONE} + {1'b0, s2_q.tanh_mag};
        out_valid_d = s2_q.valid;
        out_data_d  = out_data_q;
        if (s2_q.valid) begin
            case (s2_q.cls)
                CLS_NAN:    out_data_d = CANON_NAN;
                CLS_BYPASS: out_data_d = s2_q.data;
                default:    out_data_d = fix_to_float(!s2_q.mode && s2_q.data[31], fin_res);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sigmoid_tansig.sv
// Bench for sigmoid_tansig: real-arithmetic reference model, per-cycle output compare, directed vectors.
module tb_sigmoid_tansig;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;

    sigmoid_tansig dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    typedef struct {
        int          due;
        bit          mode;
        logic [31:0] x;
        bit          exact;
        logic [31:0] bits;
        real         ideal;
    } exp_t;

    localparam real TOL = 1.0 / 4096.0;

    exp_t        expQ [$];
    exp_t        cur;
    int          cyc = 0;
    bit          rstSeen = 1'b0;
    bit          started = 1'b0;
    logic [31:0] lastData = '0;
    int          nChecks = 0;
    int          nFails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real bitsToReal(input logic [31:0] b);
        real v;
        if (b[30:23] == 8'd0) v = real'(b[22:0]) * (2.0 ** -149.0);
        else v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
        return b[31] ? -v : v;
    endfunction

    // Reference behaviour from the mathematical definition plus the special-case rules.
    function automatic exp_t modelOf(input bit m, input logic [31:0] x);
        exp_t e;
        real  xr, xa, ex;
        xr      = bitsToReal(x);
        xa      = (xr < 0.0) ? -xr : xr;
        e.due   = 0;
        e.mode  = m;
        e.x     = x;
        e.exact = 1'b1;
        e.bits  = '0;
        e.ideal = 0.0;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) e.bits = 32'h7FC0_0000;
        else if (x[30:23] == 8'h00)                e.bits = m ? 32'h3F00_0000 : 32'h0000_0000;
        else if (!m) begin
            if (xa < TOL)       e.bits = x;
            else if (xa >= 8.0) e.bits = x[31] ? 32'hBF80_0000 : 32'h3F80_0000;
            else begin
                ex      = $exp(2.0 * xr);
                e.exact = 1'b0;
                e.ideal = (ex - 1.0) / (ex + 1.0);
            end
        end else begin
            if (xr >= 16.0)       e.bits = 32'h3F80_0000;
            else if (xr <= -16.0) e.bits = 32'h0000_0000;
            else begin
                e.exact = 1'b0;
                e.ideal = 1.0 / (1.0 + $exp(-xr));
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic checkClose(input string name, input real got, input real want, input real tol);
        real d;
        d = got - want;
        nChecks++;
        if (!(d <= tol && d >= -tol)) begin
            nFails++;
            $display("[TB] FAIL %s: got %f, expected %f (tol %f)", name, got, want, tol);
        end
    endtask

    // Called at a falling edge; the operand is accepted on the next rising edge.
    task automatic applyStimulus(input bit m, input logic [31:0] x);
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = x;
        e        = modelOf(m, x);
        e.due    = cyc + 4;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pinModel();
        exp_t e;
        e = modelOf(1'b0, 32'h0000_0000); checkOutput("pin tansig 0", e.bits, 32'h0000_0000);
        e = modelOf(1'b1, 32'h0000_0000); checkOutput("pin sigmoid 0", e.bits, 32'h3F00_0000);
        e = modelOf(1'b0, 32'h4120_0000); checkOutput("pin tansig 10", e.bits, 32'h3F80_0000);
        e = modelOf(1'b1, 32'h41A0_0000); checkOutput("pin sigmoid 20", e.bits, 32'h3F80_0000);
        e = modelOf(1'b1, 32'hC1A0_0000); checkOutput("pin sigmoid -20", e.bits, 32'h0000_0000);
        e = modelOf(1'b0, 32'h7FC0_0001); checkOutput("pin tansig nan", e.bits, 32'h7FC0_0000);
        e = modelOf(1'b0, 32'h3F80_0000); checkClose("pin tansig 1", e.ideal, 0.761594, 1.0e-5);
        e = modelOf(1'b0, 32'hBF80_0000); checkClose("pin tansig -1", e.ideal, -0.761594, 1.0e-5);
        e = modelOf(1'b1, 32'h3F80_0000); checkClose("pin sigmoid 1", e.ideal, 0.731059, 1.0e-5);
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rstSeen <= !rst_n;
        if (!rst_n) begin
            started <= 1'b1;
            expQ.delete();
        end
    end

    // One compare per falling edge: a due result, an idle hold, or a reset-cleared output.
    always @(negedge clk) begin
        if (started) begin
            if (rstSeen) begin
                checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
                checkOutput("reset out_data", out_data, 32'd0);
                lastData = 32'd0;
            end else if (expQ.size() > 0 && expQ[0].due == cyc) begin
                cur = expQ.pop_front();
                checkOutput("result out_valid", {31'b0, out_valid}, 32'd1);
                if (cur.exact)
                    checkOutput($sformatf("result m%0d x=%h", cur.mode, cur.x), out_data, cur.bits);
                else
                    checkClose($sformatf("result m%0d x=%h (bits %h)", cur.mode, cur.x, out_data),
                               bitsToReal(out_data), cur.ideal, TOL);
                lastData = out_data;
            end else begin
                checkOutput("idle out_valid", {31'b0, out_valid}, 32'd0);
                checkOutput("idle out_data hold", out_data, lastData);
            end
        end
    end

    logic [32:0] dirVec [36] = '{
        33'h0_3F800000, 33'h0_BF800000, 33'h0_41200000, 33'h1_41A00000, 33'h1_C1A00000, 33'h0_7FC00001,
        33'h1_7FC00001, 33'h0_3E800000, 33'h0_3E99999A, 33'h0_40200000, 33'h0_40700000, 33'h0_C0A00000,
        33'h0_40FCCCCD, 33'h0_40FFAE14, 33'h0_41000000, 33'h0_39000000, 33'h0_B9000000, 33'h0_39800000,
        33'h0_80000000, 33'h0_00000123, 33'h1_80000123, 33'h0_7F800000, 33'h0_FF800000, 33'h1_7F800000,
        33'h1_FF800000, 33'h1_3F800000, 33'h1_C0400000, 33'h1_41200000, 33'h1_41700000, 33'h1_C17E6666,
        33'h1_41800000, 33'h1_C1800000, 33'h1_3A83126F, 33'h0_BF333333, 33'h1_C00CCCCD, 33'h0_FF800001
    };

    logic [32:0] streamVec [8] = '{
        33'h0_3F800000, 33'h1_3F800000, 33'h0_C0400000, 33'h1_40A00000,
        33'h0_3E99999A, 33'h1_BF333333, 33'h0_7FC00001, 33'h1_00000000
    };

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 32'h3F80_0000;
        repeat (3) @(negedge clk);
        pinModel();

        $display("[TB] zero operands straight out of reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0000_0000);
        applyStimulus(1'b1, 32'h0000_0000);
        idle(4);

        $display("[TB] directed vectors");
        foreach (dirVec[i]) begin
            applyStimulus(dirVec[i][32], dirVec[i][31:0]);
            idle(1);
        end
        idle(4);

        $display("[TB] back-to-back stream");
        foreach (streamVec[i]) applyStimulus(streamVec[i][32], streamVec[i][31:0]);
        idle(6);

        $display("[TB] reset with operands in flight");
        applyStimulus(1'b0, 32'h3F80_0000);
        applyStimulus(1'b1, 32'h4020_0000);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        applyStimulus(1'b0, 32'hBF80_0000);
        idle(1);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        nChecks++;
        if (expQ.size() > 0) begin
            nFails++;
            $display("[TB] FAIL drain: got %0d results outstanding, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sigmoid_tansig.md
SIGMOID_TANSIG -- requirements
Module: sigmoid_tansig

Interface
REQ-001 SHALL have no parameters; all constants are fixed and live in the shared package.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand is presented this cycle.
REQ-005 SHALL have port in_mode, input, 1 bit: 0 = tansig (tanh), 1 = sigmoid.
REQ-006 SHALL have port in_data, input, 32 bits: IEEE-754 single-precision operand x.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a result this cycle.
REQ-008 SHALL have port out_data, output, 32 bits: IEEE-754 single-precision result.

Function
REQ-009 SHALL accept one operand per cycle with no backpressure; every accepted operand yields exactly one result, in order.
REQ-010 SHALL assert out_valid with the result exactly 3 clk cycles after the accepting edge.
REQ-011 SHALL keep out_valid low in cycles with no result; out_data holds its last value then.
REQ-012 SHALL, in tansig mode, compute tanh(x) with odd symmetry: result sign = sign(x), magnitude = tanh(|x|).
REQ-013 SHALL, in sigmoid mode, compute 0.5 + 0.5*tanh(x/2), with x/2 formed by decrementing the input exponent.
REQ-014 SHALL convert |x| to unsigned fixed point with 3 integer and 16 fractional bits.
REQ-015 SHALL look up tanh from a 257-entry Q1.16 table at |x| = k/32, k = 0..256.
REQ-016 SHALL linearly interpolate between entries k and k+1 using the 11 low fraction bits.
REQ-017 SHALL saturate tanh magnitude to exactly 1.0 when |argument| >= 8.0, including +/-Inf.
REQ-018 SHALL output x unchanged in tansig mode when |x| < 2^-12, where tanh(x) ~ x.
REQ-019 SHALL treat zero and denormal inputs as zero: tansig gives 0x00000000; sigmoid gives 0x3F000000.
REQ-020 SHALL output canonical NaN 0x7FC00000 for any NaN input in either mode.
REQ-021 SHALL normalise the fixed-point result to float with truncation; exact 1.0 encodes as 0x3F800000 and exact 0 as 0x00000000.
REQ-022 SHALL keep absolute error vs ideal tanh/sigmoid within 2^-12 over all finite inputs.
REQ-023 SHALL make sigmoid saturate to exactly 0x3F800000 for x >= 16.0 and to exactly 0x00000000 for x <= -16.0.

Reset
REQ-024 SHALL, while rst_n is low at a clk edge, clear out_valid and all internal pipeline valid bits, and set out_data to 0x00000000.
REQ-025 SHALL discard operands in flight when reset is asserted mid-operation; no stale result appears after reset release.
REQ-026 SHALL ignore in_valid during reset; the first operand is accepted on the first edge with rst_n high.

Structure
REQ-027 SHALL place the float field widths, fixed-point widths (3.16), the table step (1/32), the saturation threshold (8.0) and the canonical NaN constant in a shared package.
REQ-028 SHALL implement the 257-entry tanh table as one combinational sub-module named tanh_lut, indexed by k and returning Q1.16.
REQ-029 SHALL use a 3-stage pipeline: decode/convert, lookup/interpolate, finish/normalise.

Verification
REQ-030 SHALL pass: tansig 0x00000000 -> 0x00000000; sigmoid 0x00000000 -> 0x3F000000; both after 3 cycles.
REQ-031 SHALL pass: tansig 0x3F800000 (1.0) -> ~0x3F42F7D6 (0.761594); tansig 0xBF800000 -> ~0xBF42F7D6; each within 2^-12.
REQ-032 SHALL pass: tansig 0x41200000 (10.0) -> 0x3F800000; sigmoid 0x41A00000 (20.0) -> 0x3F800000; sigmoid 0xC1A00000 -> 0x00000000.
REQ-033 SHALL pass: NaN 0x7FC00001 in either mode -> 0x7FC00000.
REQ-034 SHALL pass: back-to-back stream of 8 mixed-mode operands -> 8 in-order results on 8 consecutive cycles, starting 3 cycles after the first.
REQ-035 SHALL pass: rst_n pulled low with 2 operands in flight -> out_valid stays low and no result for those operands ever appears.
